branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Branch history table (2-bit saturating counters) plus target buffer for the pipelined RISC-V core.
//  IF stage looks up pc_if and gets a taken/target prediction.
//  EX stage consumes the branch comparator's resolved outcome (upd_taken) and updates the tables.
//  EX stage also raises mispredict/redirect_pc back to fetch.
// PARAMETERS
//  ENTRIES     64  table depth; power of two, >=4; IDX_W = log2(ENTRIES)
//  INIT_CTR    1   counter value written at reset (2'b01 = weakly not-taken)
// PORTS
//  clk              in   1   clock, all state updates on rising edge
//  rst              in   1   asynchronous, active-high reset
//  pc_if            in   32  fetch PC to predict
//  pred_taken       out  1   prediction for pc_if
//  pred_target      out  32  predicted target (valid when pred_taken=1, else pc_if+4)
//  upd_valid        in   1   EX holds a resolved conditional branch this cycle
//  upd_pc           in   32  PC of the resolved branch
//  upd_taken        in   1   resolved outcome from the branch comparator
//  upd_target       in   32  computed branch target (pc+imm)
//  upd_pred_taken   in   1   prediction that branch carried down the pipe
//  upd_pred_target  in   32  predicted target that branch carried down the pipe
//  mispredict       out  1   EX-stage redirect request
//  redirect_pc      out  32  correct next PC when mispredict=1
// BEHAVIOUR
//  Indexing: idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
//    Per entry: valid, tag, 2-bit ctr, 32-bit target.
//  Reset (async, immediate, also mid-operation):
//    valid=0 and ctr=INIT_CTR for all entries; tags/targets don't-care.
//    Outputs during reset: pred_taken=0, mispredict=0.
//  Lookup (combinational, 0 latency):
//    hit = valid[idx] & tag match; pred_taken = hit & ctr[1].
//    pred_target = pred_taken ? target[idx] : pc_if+4 (32-bit wrap).
//  Resolution (combinational from upd_*, qualified by upd_valid):
//    mispredict = upd_valid & ((upd_taken != upd_pred_taken)
//                 | (upd_taken & upd_pred_taken & upd_pred_target != upd_target)).
//    redirect_pc = upd_taken ? upd_target : upd_pc+4.
//  Update (rising edge when upd_valid):
//    miss (invalid or tag mismatch): allocate/replace;
//      valid=1, tag, target=upd_target, ctr = upd_taken ? 2'b10 : 2'b01.
//    hit: ctr saturating inc if taken, dec if not (11 stays 11, 00 stays 00);
//      target <= upd_target when taken.
//  Same-cycle lookup and update of the same index:
//    lookup returns pre-update state; no bypass. New state is visible next cycle.
//  upd_valid=0: no state change; mispredict=0.
// CONFIGURATION
//  BP_PERF_CNT_EN defined:
//    adds outputs perf_branches[31:0] and perf_mispredicts[31:0].
//    perf_branches increments on every upd_valid; perf_mispredicts on every mispredict.
//    Both reset to 0 and wrap at 2^32.
//  BP_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package (bp_pkg):
//    counter encodings SNT=00, WNT=01, WT=10, ST=11.
//    Comparator ctrl codes EQ/NE/LT/LTU/GE/GEU = 3'b001..3'b110, shared with the EX comparator.
//  Sub-module bp_sat_counter: pure 2-bit saturating next-state function (ctr, taken) -> ctr_next.
//  Tables: flop arrays, one write port, one async read port each for IF and EX.
// TESTING
//  1 Reset, pc_if=0x100 -> pred_taken=0, pred_target=0x104.
//  2 upd pc=0x100 taken tgt=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80.
//    Next cycle pc_if=0x100 -> pred_taken=1, pred_target=0x80.
//  3 Same branch resolved taken 3x, then not-taken once -> ctr 11->10, still predicts taken.
//    Second not-taken -> ctr 01, predicts not taken.
//  4 Alias: ENTRIES=64, pc 0x100 vs 0x200 (same idx, different tag).
//    Update 0x200 evicts 0x100; lookup 0x100 -> pred_taken=0.
//  5 upd pred_taken=1, pred_target=0x80, taken, upd_target=0x90 -> mispredict=1, redirect_pc=0x90.
//    Not-taken at pc=0xFFFFFFFC -> redirect_pc=0x0.
//  6 Assert rst between update edges -> all lookups miss immediately.
//    With BP_PERF_CNT_EN, both perf counters read 0.

Source files
------------

// File: rtl/bp_pkg.sv
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared encodings for the branch predictor and the EX-stage
//                branch comparator.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package bp_pkg;

  // 2-bit saturating counter states
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Branch comparator control codes, shared with the EX comparator
  typedef enum logic [2:0] {
    CMP_EQ  = 3'b001,
    CMP_NE  = 3'b010,
    CMP_LT  = 3'b011,
    CMP_LTU = 3'b100,
    CMP_GE  = 3'b101,
    CMP_GEU = 3'b110
  } cmp_e;

  localparam int c_XLEN     = 32;
  localparam int c_INSN_INC = 4;

  function automatic logic ctr_predicts_taken(input logic [1:0] ctr);
    return ctr[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_sat_counter.sv
// ============================================================================
//  Module      : bp_sat_counter
//  Description : Next-state function of a 2-bit saturating branch counter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped branch history table (2-bit counters) plus
//                target buffer. IF-stage lookup, EX-stage resolve/update.
//                Define BP_PERF_CNT_EN to add branch/mispredict counters.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module branch_predictor
  import bp_pkg::*;
#(
  parameter int         ENTRIES  = 64,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = c_XLEN - IDX_W - 2;

  // Table state
  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];

  // IF-stage read port
  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic             w_pred_taken;

  assign w_if_idx     = pc_if[IDX_W+1:2];
  assign w_if_tag     = pc_if[31:IDX_W+2];
  assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_pred_taken = !rst && w_if_hit && ctr_predicts_taken(r_ctr[w_if_idx]);
  assign pred_taken   = w_pred_taken;
  assign pred_target  = w_pred_taken ? r_target[w_if_idx] : pc_if + 32'(c_INSN_INC);

  // EX-stage read port
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic [1:0]       w_upd_ctr_sat;
  logic [1:0]       w_upd_ctr_new;

  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[31:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  bp_sat_counter u_sat_counter (
    .ctr      (r_ctr[w_upd_idx]),
    .taken    (upd_taken),
    .ctr_next (w_upd_ctr_sat)
  );

  // A miss (re)allocates with a weak counter biased toward the observed outcome
  assign w_upd_ctr_new = w_upd_hit ? w_upd_ctr_sat
                                   : (upd_taken ? 2'(CTR_WT) : 2'(CTR_WNT));

  // Resolution; forced low while in reset
  logic w_dir_wrong;
  logic w_tgt_wrong;

  assign w_dir_wrong = (upd_taken != upd_pred_taken);
  assign w_tgt_wrong = upd_taken && upd_pred_taken && (upd_pred_target != upd_target);
  assign mispredict  = !rst && upd_valid && (w_dir_wrong || w_tgt_wrong);
  assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'(c_INSN_INC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= INIT_CTR;
      end
    end else if (upd_valid) begin
      r_valid[w_upd_idx] <= 1'b1;
      r_ctr[w_upd_idx]   <= w_upd_ctr_new;
    end
  end

  // Tags and targets are qualified by valid, so they need no reset
  always_ff @(posedge clk) begin
    if (upd_valid) begin
      r_tag[w_upd_idx] <= w_upd_tag;
      if (!w_upd_hit || upd_taken) begin
        r_target[w_upd_idx] <= upd_target;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispredicts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      if (upd_valid)  r_perf_branches    <= r_perf_branches + 32'd1;
      if (mispredict) r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
    end
  end

  assign perf_branches    = r_perf_branches;
  assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule

`default_nettype wire
